// File: rtl/memory_loader.sv
// rtl/memory_loader.sv - bus-attached RAM with address register and streaming program loader
// Optional: MEM_ADDR_AUTOINC_EN makes an IDLE write without MI post-increment the address.
module memory_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MI,
  input  logic              WE,
  input  logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] addr,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              busy,
  output logic              prog_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_prog_ready;
  logic              r_busy;
  logic              r_prog_done;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_cpu_we;
  logic              w_ld_we;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  // prog_start wins over a CPU write issued in the same IDLE cycle
  assign w_cpu_we  = (r_state == S_IDLE) && WE && !prog_start;
  assign w_ld_we   = (r_state == S_LOAD) && prog_valid && r_prog_ready;
  assign w_wr_en   = w_cpu_we || w_ld_we;
  assign w_wr_addr = w_ld_we ? r_ptr : r_addr;
  assign w_wr_data = w_ld_we ? prog_data : bus;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_ptr        <= '0;
      r_prog_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_prog_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (prog_start) begin
            r_ptr        <= '0;
            r_state      <= S_LOAD;
            r_busy       <= 1'b1;
            r_prog_ready <= 1'b1;
          end else if (MI) begin
            r_addr <= bus[ADDR_W-1:0];
`ifdef MEM_ADDR_AUTOINC_EN
          end else if (WE) begin
            r_addr <= r_addr + 1'b1;
`endif
          end
        end
        S_LOAD: begin
          if (w_ld_we) begin
            r_ptr <= r_ptr + 1'b1;
            // the pointer wraps, so the last slot ends the load even without prog_last
            if (prog_last || (&r_ptr)) begin
              r_state      <= S_DONE;
              r_prog_ready <= 1'b0;
              r_prog_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_prog_done <= 1'b0;
          r_addr      <= '0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_prog_ready <= 1'b0;
          r_prog_done  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_out    = r_mem[r_addr];
  assign addr       = r_addr;
  assign prog_ready = r_prog_ready;
  assign busy       = r_busy;
  assign prog_done  = r_prog_done;

endmodule

// File: tb/tb_memory_loader.sv
// tb/tb_memory_loader.sv - self-checking bench for memory_loader (DATA_W=8, ADDR_W=4)
module tb_memory_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       MI;
  logic       WE;
  logic [7:0] bus;
  logic [7:0] mem_out;
  logic [3:0] addr;
  logic       prog_start;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_last;
  logic       prog_ready;
  logic       busy;
  logic       prog_done;

  memory_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .MI(MI), .WE(WE), .bus(bus),
    .mem_out(mem_out), .addr(addr),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready), .busy(busy), .prog_done(prog_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mi;
    logic       we;
    logic [7:0] bus;
    logic [3:0] exp_addr;
    logic       chk_mem;
    logic [7:0] exp_mem;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] q_exp [$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (prog_done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic last);
    logic acc;
    prog_valid = 1'b1;
    prog_data  = d;
    prog_last  = last;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = prog_ready;
      step();
    end
    check("word_accepted", acc, 1'b1);
    q_exp.push_back(d);
  endtask

  task automatic readback(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      MI  = 1'b1;
      bus = 8'(i);
      step();
      MI = 1'b0;
      if (q_exp.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        e = q_exp.pop_front();
        check($sformatf("readback_mem%0d", i), mem_out, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int done_before;
    vecs[0] = '{1'b1, 1'b0, 8'h08, 4'h8, 1'b0, 8'h00};
`ifdef MEM_ADDR_AUTOINC_EN
    vecs[1] = '{1'b0, 1'b1, 8'h3C, 4'h9, 1'b0, 8'h00};
`else
    vecs[1] = '{1'b0, 1'b1, 8'h3C, 4'h8, 1'b1, 8'h3C};
`endif
    vecs[2] = '{1'b1, 1'b0, 8'h18, 4'h8, 1'b1, 8'h3C};
    vecs[3] = '{1'b1, 1'b0, 8'h05, 4'h5, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'h77, 4'h7, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'h05, 4'h5, 1'b1, 8'h77};
`ifdef MEM_ADDR_AUTOINC_EN
    vecs[6] = '{1'b0, 1'b1, 8'h99, 4'h6, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 8'h05, 4'h5, 1'b1, 8'h99};
`else
    vecs[6] = '{1'b0, 1'b1, 8'h99, 4'h5, 1'b1, 8'h99};
    vecs[7] = '{1'b0, 1'b0, 8'hEE, 4'h5, 1'b1, 8'h99};
`endif

    rst = 1'b0; MI = 1'b0; WE = 1'b0; bus = 8'h00;
    prog_start = 1'b0; prog_valid = 1'b0; prog_data = 8'h00; prog_last = 1'b0;
    step(); step();
    check("rst_addr", addr, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", prog_ready, 1'b0);
    check("rst_done", prog_done, 1'b0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      MI = vecs[i].mi; WE = vecs[i].we; bus = vecs[i].bus;
      step();
      MI = 1'b0; WE = 1'b0;
      check($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
      if (vecs[i].chk_mem) check($sformatf("vec%0d_mem", i), mem_out, vecs[i].exp_mem);
    end

`ifdef MEM_ADDR_AUTOINC_EN
    MI = 1'b1; bus = 8'h0F; step(); MI = 1'b0;
    WE = 1'b1; bus = 8'h11; step();
    bus = 8'h22; step(); WE = 1'b0;
    check("autoinc_addr", addr, 4'h1);
    MI = 1'b1; bus = 8'h0F; step();
    check("autoinc_mem15", mem_out, 8'h11);
    bus = 8'h00; step(); MI = 1'b0;
    check("autoinc_mem0", mem_out, 8'h22);
`endif

    // asynchronous reset while idle
    MI = 1'b1; bus = 8'h05; step(); MI = 1'b0;
    check("pre_reset_addr", addr, 4'h5);
    #2 rst = 1'b0;
    #1;
    check("async_rst_addr", addr, 4'h0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", prog_done, 1'b0);
    rst = 1'b1;
    step();

    // load 1: prog_start beats MI in the same cycle, four words ending on prog_last
    prog_start = 1'b1; MI = 1'b1; bus = 8'h0C;
    step();
    prog_start = 1'b0; MI = 1'b0;
    check("load1_busy", busy, 1'b1);
    check("load1_ready", prog_ready, 1'b1);
    check("load1_addr_held", addr, 4'h0);
    done_before = done_cnt;
    send_word(8'h18, 1'b0);
    send_word(8'h28, 1'b0);
    send_word(8'hE0, 1'b0);
    send_word(8'hF0, 1'b1);
    prog_valid = 1'b0; prog_last = 1'b0;
    check("load1_done_pulse", prog_done, 1'b1);
    check("load1_done_busy", busy, 1'b1);
    check("load1_done_ready", prog_ready, 1'b0);
    step();
    check("load1_exit_done", prog_done, 1'b0);
    check("load1_exit_busy", busy, 1'b0);
    check("load1_exit_addr", addr, 4'h0);
    check("load1_exit_mem", mem_out, 8'h18);
    step();
    check("load1_done_count", done_cnt - done_before, 1);
    readback(4);

    // load 2: CPU commands ignored in LOAD, 16 words without prog_last
    MI = 1'b1; bus = 8'h09; step(); MI = 1'b0;
    WE = 1'b1; bus = 8'h42; step(); WE = 1'b0;
    MI = 1'b1; bus = 8'h09; step(); MI = 1'b0;
    check("load2_pre_mem", mem_out, 8'h42);
    prog_start = 1'b1; step(); prog_start = 1'b0;
    WE = 1'b1; bus = 8'hAA; step(); WE = 1'b0;
    check("load2_we_ignored", mem_out, 8'h42);
    MI = 1'b1; bus = 8'h03; step(); MI = 1'b0;
    check("load2_mi_ignored", addr, 4'h9);
    done_before = done_cnt;
    for (int i = 0; i < 16; i++) begin
      send_word(8'h80 + 8'(i), 1'b0);
      if (i == 9) check("load2_mem_out_live", mem_out, 8'h89);
    end
    check("load2_done_after16", prog_done, 1'b1);
    prog_data = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("load2_word17_ready%0d", k), prog_ready, 1'b0);
      step();
    end
    prog_valid = 1'b0;
    check("load2_exit_addr", addr, 4'h0);
    check("load2_done_count", done_cnt - done_before, 1);
    readback(16);

    // reset in the middle of a stream
    prog_start = 1'b1; step(); prog_start = 1'b0;
    done_before = done_cnt;
    send_word(8'hC1, 1'b0);
    send_word(8'hC2, 1'b0);
    prog_data = 8'hC3;
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", prog_ready, 1'b0);
    check("midrst_addr", addr, 4'h0);
    rst = 1'b1;
    step();
    prog_valid = 1'b0;
    check("midrst_idle_ready", prog_ready, 1'b0);
    step();
    check("midrst_no_done", done_cnt - done_before, 0);
    readback(2);
    MI = 1'b1; bus = 8'h02; step(); MI = 1'b0;
    check("midrst_mem2_kept", mem_out, 8'h82);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
